// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: stall/flush sequencer state and forwarding selects
// used by the hazard unit and the Execute operand muxes.
package pipeline_pkg;

    typedef enum logic {
        RUN,
        MDU_BUSY
    } ctrl_state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges memory wait states, MDU occupancy, branch
// redirects and load-use stalls into per-stage enables/flushes, plus a stall counter.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int MDU_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use_stall,
    input  logic        branch_taken_e,
    input  logic        mdu_req_e,
    input  logic        mem_req_m,
    input  logic        dmem_ready,
    output logic        en_f,
    output logic        en_d,
    output logic        en_e,
    output logic        en_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m,
    output logic        flush_w,
    output logic        mdu_start,
    output logic        mdu_done,
    output logic        mdu_busy,
    output logic [31:0] stall_count
);

    localparam int CNT_W = $clog2(MDU_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

    ctrl_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             mem_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (!en_f)
                stall_count <= stall_count + 32'd1;
        end
    end

    always_comb begin
        mem_wait  = mem_req_m && !dmem_ready;
        state_d   = state;
        cnt_d     = cnt;
        en_f      = 1'b1;
        en_d      = 1'b1;
        en_e      = 1'b1;
        en_m      = 1'b1;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        flush_w   = 1'b0;
        mdu_start = 1'b0;
        mdu_done  = 1'b0;
        mdu_busy  = (state == MDU_BUSY);

        if (rst) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            flush_m  = 1'b1;
            flush_w  = 1'b1;
            mdu_busy = 1'b0;
        end else if (mem_wait) begin
            // Whole pipe freezes; only the M/W slot is bubbled. FSM and cnt hold.
            en_f    = 1'b0;
            en_d    = 1'b0;
            en_e    = 1'b0;
            en_m    = 1'b0;
            flush_w = 1'b1;
        end else if (state == MDU_BUSY) begin
            if (cnt != '0) begin
                en_f    = 1'b0;
                en_d    = 1'b0;
                en_e    = 1'b0;
                flush_m = 1'b1;
                cnt_d   = cnt - CNT_W'(1);
            end else begin
                mdu_done = 1'b1;
                state_d  = RUN;
            end
        end else if (mdu_req_e) begin
            en_f      = 1'b0;
            en_d      = 1'b0;
            en_e      = 1'b0;
            flush_m   = 1'b1;
            mdu_start = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = MDU_BUSY;
        end else if (branch_taken_e) begin
            // The load-use victim sits in Decode and is flushed, so no stall is needed.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use_stall) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            flush_e = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int MDU_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst, load_use_stall, branch_taken_e, mdu_req_e, mem_req_m, dmem_ready;
    logic        en_f, en_d, en_e, en_m;
    logic        flush_d, flush_e, flush_m, flush_w;
    logic        mdu_start, mdu_done, mdu_busy;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Model state: whether an MDU op is in flight and how many non-wait cycles it has run.
    bit        m_busy    = 1'b0;
    int        m_elapsed = 0;
    bit [31:0] m_stall   = '0;

    pipeline_ctrl #(.MDU_CYCLES(MDU_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .load_use_stall(load_use_stall), .branch_taken_e(branch_taken_e),
        .mdu_req_e(mdu_req_e), .mem_req_m(mem_req_m), .dmem_ready(dmem_ready),
        .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .mdu_start(mdu_start), .mdu_done(mdu_done), .mdu_busy(mdu_busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Order: en_f en_d en_e en_m flush_d flush_e flush_m flush_w start done busy
    always @(negedge clk) begin
        if (checking) begin
            bit [10:0] exp_v;
            bit e_f, e_d, e_e, e_m, f_d, f_e, f_m, f_w, st, dn, bz;
            bit mem_wait;
            mem_wait = mem_req_m && !dmem_ready;
            {e_f, e_d, e_e, e_m} = 4'b1111;
            {f_d, f_e, f_m, f_w} = 4'b0000;
            st = 1'b0; dn = 1'b0; bz = m_busy;
            chk("stall_count", stall_count, m_stall);
            if (rst) begin
                {f_d, f_e, f_m, f_w} = 4'b1111;
                bz = 1'b0;
                m_busy = 1'b0; m_elapsed = 0;
            end else if (mem_wait) begin
                {e_f, e_d, e_e, e_m} = 4'b0000;
                f_w = 1'b1;
            end else if (m_busy) begin
                if (m_elapsed == MDU_CYCLES) begin
                    dn = 1'b1;
                    m_busy = 1'b0;
                end else begin
                    {e_f, e_d, e_e} = 3'b000;
                    f_m = 1'b1;
                    m_elapsed++;
                end
            end else if (mdu_req_e) begin
                {e_f, e_d, e_e} = 3'b000;
                f_m = 1'b1;
                st = 1'b1;
                m_busy = 1'b1; m_elapsed = 1;
            end else if (branch_taken_e) begin
                f_d = 1'b1; f_e = 1'b1;
            end else if (load_use_stall) begin
                e_f = 1'b0; e_d = 1'b0; f_e = 1'b1;
            end
            exp_v = {e_f, e_d, e_e, e_m, f_d, f_e, f_m, f_w, st, dn, bz};
            chk("ctrl_vector",
                {21'd0, en_f, en_d, en_e, en_m, flush_d, flush_e, flush_m, flush_w,
                 mdu_start, mdu_done, mdu_busy},
                {21'd0, exp_v});
            if (rst) m_stall = '0;
            else if (!e_f) m_stall = m_stall + 32'd1;
        end
    end

    task automatic drive(input bit r, input bit lu, input bit br, input bit md,
                         input bit mq, input bit rd);
        @(posedge clk); #1;
        rst = r; load_use_stall = lu; branch_taken_e = br;
        mdu_req_e = md; mem_req_m = mq; dmem_ready = rd;
        #2;
    endtask

    initial begin
        rst = 1'b1; load_use_stall = 1'b0; branch_taken_e = 1'b0;
        mdu_req_e = 1'b0; mem_req_m = 1'b0; dmem_ready = 1'b1;

        drive(1, 0, 0, 0, 0, 1);
        checking = 1'b1;
        chk("rst_en_f", en_f, 1);
        chk("rst_flush_d", flush_d, 1);
        chk("rst_flush_w", flush_w, 1);
        chk("rst_busy", mdu_busy, 0);
        chk("rst_stall_count", stall_count, 0);

        drive(0, 0, 0, 0, 0, 1);
        chk("idle_en_f", en_f, 1);
        chk("idle_flush_e", flush_e, 0);

        // Load-use: one bubble
        drive(0, 1, 0, 0, 0, 1);
        chk("lu_en_f", en_f, 0);
        chk("lu_en_d", en_d, 0);
        chk("lu_flush_e", flush_e, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("lu_stall_count", stall_count, 1);

        // Branch overrides load-use
        drive(0, 1, 1, 0, 0, 1);
        chk("br_flush_d", flush_d, 1);
        chk("br_flush_e", flush_e, 1);
        chk("br_en_f", en_f, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("br_stall_count", stall_count, 1);

        // Single MDU op
        for (int i = 0; i <= 4; i++) begin
            drive(0, 0, 0, 1, 0, 1);
            chk("mdu_start", mdu_start, (i == 0));
            chk("mdu_busy", mdu_busy, (i >= 1));
            chk("mdu_done", mdu_done, (i == 4));
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("mdu_stall_count", stall_count, 5);

        // MDU op with two memory wait cycles at cycles 2 and 3
        for (int i = 0; i <= 6; i++) begin
            drive(0, 0, 0, 1, (i == 2 || i == 3), 0);
            chk("mw_done", mdu_done, (i == 6));
            chk("mw_en_m", en_m, !(i == 2 || i == 3));
            chk("mw_flush_w", flush_w, (i == 2 || i == 3));
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("mw_stall_count", stall_count, 11);

        // Back-to-back MDU ops
        for (int i = 0; i <= 9; i++) begin
            drive(0, 0, 0, 1, 0, 1);
            chk("b2b_start", mdu_start, (i == 0 || i == 5));
            chk("b2b_done", mdu_done, (i == 4 || i == 9));
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("b2b_stall_count", stall_count, 19);

        // Reset during MDU_BUSY aborts the op
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 1, 0, 1);
        chk("abort_rst_en_f", en_f, 1);
        chk("abort_rst_flush_w", flush_w, 1);
        chk("abort_rst_busy", mdu_busy, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            chk("abort_busy", mdu_busy, 0);
            chk("abort_done", mdu_done, 0);
            chk("abort_en_f", en_f, 1);
        end
        chk("abort_stall_count", stall_count, 0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 1),
                  ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < 60));
        end
        drive(0, 0, 0, 0, 0, 1);
        @(posedge clk);
        checking = 1'b0;

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. Merges the load-use stall from the data hazard unit, branch redirects from Execute, data-memory wait states and a multi-cycle multiply/divide unit (MDU) into one consistent set of per-stage register enables and flushes. It also issues the MDU start pulse and keeps a stall-cycle performance counter. Sits in the top level beside the hazard unit and drives the PC register and the F/D, D/E, E/M and M/W pipeline registers.

## Interface
- MDU_CYCLES, 32, MDU execution latency in cycles; legal range 1..255
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- load_use_stall  in  1  load-use hazard on the instruction in Decode (hazard unit `stall`)
- branch_taken_e  in  1  taken branch/jump resolved in Execute; PC redirect this cycle
- mdu_req_e  in  1  the instruction in Execute is a mul/div
- mem_req_m  in  1  the instruction in Memory accesses data memory
- dmem_ready  in  1  data memory completes the Memory-stage access this cycle
- en_f, en_d, en_e, en_m  out  1 each  load enables: PC, F/D, D/E and E/M registers
- flush_d, flush_e, flush_m, flush_w  out  1 each  load a bubble into F/D, D/E, E/M and M/W
- mdu_start  out  1  one-cycle start pulse to the MDU
- mdu_done  out  1  MDU result is valid; the Execute instruction advances this cycle
- mdu_busy  out  1  FSM is in MDU_BUSY
- stall_count  out  32  count of cycles with en_f == 0

## Operation
- FSM states: RUN, MDU_BUSY. Down-counter `cnt` has width $clog2(MDU_CYCLES+1).
- mem_wait = mem_req_m && !dmem_ready.
- Request priority, highest first: mem_wait, MDU, branch, load-use.
- mem_wait, in any state:
  - en_f, en_d, en_e and en_m are 0.
  - flush_w = 1.
  - cnt and state hold.
  - mdu_start and mdu_done are 0.
- RUN with mdu_req_e and no mem_wait:
  - en_f, en_d and en_e are 0; flush_m = 1.
  - mdu_start = 1, cnt <= MDU_CYCLES-1, next state MDU_BUSY.
- MDU_BUSY with no mem_wait and cnt != 0:
  - en_f, en_d and en_e are 0; flush_m = 1.
  - cnt decrements.
- MDU_BUSY with no mem_wait and cnt == 0:
  - mdu_done = 1; all enables are 1.
  - Next state RUN.
- branch_taken_e and load_use_stall are ignored while in MDU_BUSY.
- RUN with branch_taken_e and no higher-priority request:
  - flush_d = flush_e = 1; all enables are 1.
  - This overrides load_use_stall, because the stalled instruction is being flushed.
- RUN with load_use_stall only:
  - en_f = en_d = 0; flush_e = 1.
- Otherwise every enable is 1 and every flush is 0.
- stall_count increments in each non-reset cycle where en_f == 0, and wraps at 2^32.

## Timing
- All enables and flushes are combinational from the current inputs, state and cnt. They act on the same clock edge.
- Load-use inserts exactly 1 bubble.
- A branch costs 2 flushed slots.
- An MDU instruction occupies Execute for MDU_CYCLES+1 cycles. That is MDU_CYCLES stall cycles before mem_wait extensions.
- mdu_start is asserted in the entry cycle.
- mdu_done is asserted MDU_CYCLES cycles after mdu_start, provided no mem_wait occurs.
- Each mem_wait cycle extends the stall by exactly one cycle, including when it occurs inside MDU_BUSY.
- Back-to-back MDU instructions: the second starts the cycle after mdu_done.
- Reset:
  - state RUN, cnt 0, stall_count 0.
  - While rst is high: all enables 1, all flushes 1, mdu_start/mdu_done/mdu_busy 0.
  - Reset in MDU_BUSY aborts the operation; no mdu_done is produced.
- MDU_CYCLES = 1: the MDU_BUSY state lasts exactly one cycle, with mdu_done asserted.

## Structure
- The shared `pipeline_pkg` holds:
  - `ctrl_state_t` enum {RUN, MDU_BUSY};
  - the forwarding select constants FWD_NONE = 2'b00, FWD_WB = 2'b01 and FWD_MEM = 2'b10, used by the hazard unit and the Execute muxes.
- No sub-module. The FSM, cnt and stall_count are inline in one always_ff, with one always_comb for the outputs.

## Test plan
- load_use_stall = 1 for one cycle in RUN -> en_f = en_d = 0, flush_e = 1 for 1 cycle; stall_count goes 0 -> 1.
- branch_taken_e = 1 together with load_use_stall = 1 -> flush_d = flush_e = 1, en_f = 1; stall_count unchanged.
- MDU_CYCLES = 4, mdu_req_e held -> mdu_start at cycle 0, mdu_busy for cycles 1-4, mdu_done at cycle 4; stall_count = 4.
- MDU_CYCLES = 4 with mem_req_m = 1, dmem_ready = 0 for 2 cycles at cycle 2 -> en_m = 0, flush_w = 1 for those 2 cycles, cnt holds, mdu_done moves to cycle 6.
- Two back-to-back mul instructions with MDU_CYCLES = 2 -> mdu_start at cycles 0 and 3, mdu_done at cycles 2 and 5.
- rst asserted at cycle 2 of an MDU operation -> next cycle state RUN, mdu_busy = 0, stall_count = 0, no mdu_done.
